// File: rtl/stone_drawer.sv
// Per-frame stone rasteriser: walks the stone RAM and emits erase/draw pixel plots.
// Optional macro STONE_DRAWER_HILITE_EN draws moving stones with an all-ones 1-px border.
module stone_drawer #(
  parameter int                   FRAME_CLOCK = 833_334,
  parameter int                   BOX         = 16,
  parameter int                   COLOUR_W    = 3,
  parameter logic [COLOUR_W-1:0]  BG_COLOUR   = 3'b000,
  parameter logic [COLOUR_W-1:0]  C_STONE     = 3'b111,
  parameter logic [COLOUR_W-1:0]  C_GOLD      = 3'b110,
  parameter logic [COLOUR_W-1:0]  C_DIAMOND   = 3'b011
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                enable,
  input  logic [3:0]          quantity,
  input  logic [31:0]         stone_data,
  output logic                draw_stone_flag,
  output logic [3:0]          draw_index,
  output logic [8:0]          vga_x,
  output logic [7:0]          vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  localparam int LOG_BOX = $clog2(BOX);
  localparam int PIX_W   = 2 * LOG_BOX;
  localparam int CNT_W   = $clog2(FRAME_CLOCK + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT, S_SCAN, S_RD_ADDR, S_RD_WAIT, S_RD_LATCH,
    S_ERASE, S_DRAW, S_NEXT, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         qty;
  logic [PIX_W-1:0]   pix;
  logic [15:0]        prev_valid;
  logic [8:0]         prev_x [16];
  logic [7:0]         prev_y [16];
  logic [8:0]         rx;
  logic [7:0]         ry;
  logic [1:0]         rtype;
  logic               rvis;
`ifdef STONE_DRAWER_HILITE_EN
  logic               rmov;
`endif

  logic [8:0]          sd_x;
  logic [7:0]          sd_y;
  logic                sd_vis;
  logic                erase_need;
  logic                pix_last;
  logic [LOG_BOX-1:0]  col;
  logic [LOG_BOX-1:0]  row;
  logic [8:0]          base_x;
  logic [7:0]          base_y;
  logic [9:0]          sum_x;
  logic [8:0]          sum_y;
  logic                in_screen;
  logic                border;
  logic [COLOUR_W-1:0] pix_colour;
  logic                unused_bits;

  assign sd_x     = stone_data[31:23];
  assign sd_y     = stone_data[18:11];
  assign sd_vis   = stone_data[1];
  assign pix_last = &pix;
  assign col      = pix[LOG_BOX-1:0];
  assign row      = pix[PIX_W-1:LOG_BOX];
  assign border   = (~|col) | (&col) | (~|row) | (&row);
`ifdef STONE_DRAWER_HILITE_EN
  assign unused_bits = ^{stone_data[22:19], stone_data[10:4], border};
`else
  assign unused_bits = ^{stone_data[22:19], stone_data[10:4], stone_data[0], border};
`endif

  function automatic logic [COLOUR_W-1:0] type_colour(input logic [1:0] t);
    case (t)
      2'd0:    type_colour = C_STONE;
      2'd1:    type_colour = C_GOLD;
      default: type_colour = C_DIAMOND;
    endcase
  endfunction

  // Erase when the old box is no longer where the record now says it is.
  assign erase_need = prev_valid[draw_index] &&
                      (!sd_vis || prev_x[draw_index] != sd_x || prev_y[draw_index] != sd_y);

  always_comb begin
    base_x     = rx;
    base_y     = ry;
    pix_colour = type_colour(rtype);
    if (state == S_ERASE) begin
      base_x     = prev_x[draw_index];
      base_y     = prev_y[draw_index];
      pix_colour = BG_COLOUR;
    end
`ifdef STONE_DRAWER_HILITE_EN
    else if (rmov && border) begin
      pix_colour = '1;
    end
`endif
    sum_x     = {1'b0, base_x} + 10'(col);
    sum_y     = {1'b0, base_y} + 9'(row);
    in_screen = (sum_x < 10'd320) && (sum_y < 9'd240);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (enable) state_nx = S_WAIT;
      S_WAIT: begin
        if (!enable)                               state_nx = S_IDLE;
        else if (cnt == CNT_W'(FRAME_CLOCK - 1))   state_nx = S_SCAN;
      end
      S_SCAN:     state_nx = (quantity == 4'd0) ? S_DONE : S_RD_ADDR;
      S_RD_ADDR:  state_nx = S_RD_WAIT;
      S_RD_WAIT:  state_nx = S_RD_LATCH;
      S_RD_LATCH: begin
        if (erase_need)  state_nx = S_ERASE;
        else if (sd_vis) state_nx = S_DRAW;
        else             state_nx = S_NEXT;
      end
      S_ERASE:    if (pix_last) state_nx = rvis ? S_DRAW : S_NEXT;
      S_DRAW:     if (pix_last) state_nx = S_NEXT;
      S_NEXT:     state_nx = (draw_index == qty - 4'd1) ? S_DONE : S_RD_ADDR;
      S_DONE:     state_nx = S_WAIT;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Control state: FSM, frame counter, scan index, prev-table validity, plot port.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state           <= S_IDLE;
      cnt             <= '0;
      qty             <= '0;
      pix             <= '0;
      prev_valid      <= '0;
      draw_stone_flag <= 1'b0;
      draw_index      <= '0;
      vga_x           <= '0;
      vga_y           <= '0;
      vga_colour      <= '0;
      vga_plot        <= 1'b0;
    end else begin
      state    <= state_nx;
      vga_plot <= 1'b0;
      case (state)
        S_IDLE: cnt <= '0;
        S_WAIT: cnt <= cnt + CNT_W'(1);
        S_SCAN: begin
          qty             <= quantity;
          draw_index      <= '0;
          pix             <= '0;
          draw_stone_flag <= 1'b1;
        end
        S_ERASE, S_DRAW: begin
          pix        <= pix + PIX_W'(1);
          vga_x      <= sum_x[8:0];
          vga_y      <= sum_y[7:0];
          vga_colour <= pix_colour;
          vga_plot   <= in_screen;
          if (pix_last) prev_valid[draw_index] <= (state == S_DRAW);
        end
        S_NEXT: if (draw_index != qty - 4'd1) draw_index <= draw_index + 4'd1;
        S_DONE: begin
          draw_stone_flag <= 1'b0;
          draw_index      <= '0;
          cnt             <= '0;
        end
        default: ;
      endcase
    end
  end

  // Record latch and prev-position table contents.
  always_ff @(posedge clock) begin
    if (state == S_RD_LATCH) begin
      rx    <= sd_x;
      ry    <= sd_y;
      rtype <= stone_data[3:2];
      rvis  <= sd_vis;
`ifdef STONE_DRAWER_HILITE_EN
      rmov  <= stone_data[0];
`endif
    end
    if (state == S_DRAW && pix_last) begin
      prev_x[draw_index] <= rx;
      prev_y[draw_index] <= ry;
    end
  end

endmodule
